// File: rtl/battlefront_ctrl_if.sv
// Bus between battlefront_ctrl and the enemy/player unit slot arrays.
// The optional tickCount signal exists only when BATTLE_TICK_CNT_EN is defined.
// master: the combat arbiter. slave: the unit arrays and the score/VGA side.
interface battlefront_ctrl_if #(
    parameter int NUM_SLOTS = 4
);
    logic                      gameClk;
    logic [9*NUM_SLOTS-1:0]    enemyPos;
    logic [2*NUM_SLOTS-1:0]    enemyType;
    logic [8*NUM_SLOTS-1:0]    enemyDmg;
    logic [9*NUM_SLOTS-1:0]    playerPos;
    logic [2*NUM_SLOTS-1:0]    playerType;
    logic [8*NUM_SLOTS-1:0]    playerDmg;
    logic                      moveSCEN;
    logic                      damageSCEN;
    logic [8:0]                enemyFront;
    logic [8:0]                playerFront;
    logic [8*NUM_SLOTS-1:0]    enemyDamageIn;
    logic [8*NUM_SLOTS-1:0]    playerDamageIn;
    logic                      busy;
    logic                      baseHit;
    logic                      overrun;
`ifdef BATTLE_TICK_CNT_EN
    logic [15:0]               tickCount;
`endif

    modport master (
        input  gameClk, enemyPos, enemyType, enemyDmg,
        input  playerPos, playerType, playerDmg,
        output moveSCEN, damageSCEN, enemyFront, playerFront,
        output enemyDamageIn, playerDamageIn, busy, baseHit, overrun
`ifdef BATTLE_TICK_CNT_EN
        , output tickCount
`endif
    );

    modport slave (
        output gameClk, enemyPos, enemyType, enemyDmg,
        output playerPos, playerType, playerDmg,
        input  moveSCEN, damageSCEN, enemyFront, playerFront,
        input  enemyDamageIn, playerDamageIn, busy, baseHit, overrun
`ifdef BATTLE_TICK_CNT_EN
        , input tickCount
`endif
    );
endinterface

// File: rtl/battlefront_ctrl.sv
// battlefront_ctrl: per game tick, scan all slots for the enemy/player fronts,
// strobe movement, collect damageOut and route summed damage to the opposing
// frontmost unit. Optional feature macro: BATTLE_TICK_CNT_EN (adds tickCount).
module battlefront_ctrl #(
    parameter int         NUM_SLOTS = 4,
    parameter logic [8:0] FIELD_END = 9'd319,
    parameter logic [8:0] BASE_LINE = 9'd300
) (
    input  logic                 clk,
    input  logic                 reset,
    battlefront_ctrl_if.master   bus
);
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_SLOTS - 1);

    localparam logic [2:0] QIdle    = 3'd0;
    localparam logic [2:0] QScan    = 3'd1;
    localparam logic [2:0] QMove    = 3'd2;
    localparam logic [2:0] QCollect = 3'd3;
    localparam logic [2:0] QDamage  = 3'd4;

    // Slot-indexed views of the flat unit buses
    logic [NUM_SLOTS-1:0][8:0] ePos, pPos;
    logic [NUM_SLOTS-1:0][1:0] eTy, pTy;
    logic [NUM_SLOTS-1:0][7:0] eDm, pDm;
    assign ePos = bus.enemyPos;
    assign pPos = bus.playerPos;
    assign eTy  = bus.enemyType;
    assign pTy  = bus.playerType;
    assign eDm  = bus.enemyDmg;
    assign pDm  = bus.playerDmg;

    logic [2:0]    state_q, state_d;
    logic          gclk_q, pending_q, overrun_q, basehit_q;
    logic [IW-1:0] cnt_q;
    logic [8:0]    run_e_q, run_p_q, efront_q, pfront_q;
    logic          e_found_q, p_found_q;
    logic [IW-1:0] e_idx_q, p_idx_q;
    logic [NUM_SLOTS-1:0][7:0] edmg_q, pdmg_q, edmg_d, pdmg_d;
`ifdef BATTLE_TICK_CNT_EN
    logic [15:0]   tick_cnt_q;
`endif

    logic          tick, last;
    logic          e_take, p_take;
    logic [8:0]    run_e_nx, run_p_nx;
    logic [10:0]   e_sum, p_sum;
    logic [7:0]    e_sat, p_sat;

    assign tick = bus.gameClk & ~gclk_q;
    assign last = (cnt_q == LAST);

    // One scan step: strict compare keeps ties on the lowest slot index; the
    // found flag lets a unit at the starting value still claim the front.
    always_comb begin
        e_take   = (eTy[cnt_q] != 2'b00) && (!e_found_q || ePos[cnt_q] > run_e_q);
        p_take   = (pTy[cnt_q] != 2'b00) && (!p_found_q || pPos[cnt_q] < run_p_q);
        run_e_nx = e_take ? ePos[cnt_q] : run_e_q;
        run_p_nx = p_take ? pPos[cnt_q] : run_p_q;
    end

    // Damage sums over alive units, 11-bit then saturated to a byte
    always_comb begin
        e_sum = '0;
        p_sum = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (eTy[i] != 2'b00) e_sum = e_sum + {3'b000, eDm[i]};
            if (pTy[i] != 2'b00) p_sum = p_sum + {3'b000, pDm[i]};
        end
        e_sat = (|e_sum[10:8]) ? 8'hFF : e_sum[7:0];
        p_sat = (|p_sum[10:8]) ? 8'hFF : p_sum[7:0];
    end

    // Damage routing: each side's sum lands only on the opposing front unit
    always_comb begin
        edmg_d = '0;
        pdmg_d = '0;
        if (e_found_q) edmg_d[e_idx_q] = p_sat;
        if (p_found_q) pdmg_d[p_idx_q] = e_sat;
    end

    // Sequencer next state; a pending tick restarts the scan from idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            QIdle:    if (tick || pending_q) state_d = QScan;
            QScan:    if (last) state_d = QMove;
            QMove:    state_d = QCollect;
            QCollect: state_d = QDamage;
            QDamage:  state_d = QIdle;
            default:  state_d = QIdle;
        endcase
    end

    // Sequencer, scan scratch, published fronts, damage buses and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= QIdle;
            gclk_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            basehit_q <= 1'b0;
            cnt_q     <= '0;
            run_e_q   <= '0;
            run_p_q   <= FIELD_END;
            e_found_q <= 1'b0;
            p_found_q <= 1'b0;
            e_idx_q   <= '0;
            p_idx_q   <= '0;
            efront_q  <= '0;
            pfront_q  <= FIELD_END;
            edmg_q    <= '0;
            pdmg_q    <= '0;
`ifdef BATTLE_TICK_CNT_EN
            tick_cnt_q <= '0;
`endif
        end else begin
            gclk_q  <= bus.gameClk;
            state_q <= state_d;

            if (state_q == QIdle) begin
                if (tick || pending_q) pending_q <= 1'b0;
            end else if (tick) begin
                if (pending_q) overrun_q <= 1'b1;
                else           pending_q <= 1'b1;
            end

            case (state_q)
                QIdle: if (state_d == QScan) begin
                    cnt_q     <= '0;
                    run_e_q   <= '0;
                    run_p_q   <= FIELD_END;
                    e_found_q <= 1'b0;
                    p_found_q <= 1'b0;
                    e_idx_q   <= '0;
                    p_idx_q   <= '0;
                end
                QScan: begin
                    cnt_q   <= cnt_q + 1'b1;
                    run_e_q <= run_e_nx;
                    run_p_q <= run_p_nx;
                    if (e_take) begin
                        e_found_q <= 1'b1;
                        e_idx_q   <= cnt_q;
                    end
                    if (p_take) begin
                        p_found_q <= 1'b1;
                        p_idx_q   <= cnt_q;
                    end
                    if (last) begin
                        efront_q <= run_e_nx;
                        pfront_q <= run_p_nx;
                        if (run_e_nx >= BASE_LINE) basehit_q <= 1'b1;
`ifdef BATTLE_TICK_CNT_EN
                        tick_cnt_q <= tick_cnt_q + 16'd1;
`endif
                    end
                end
                QCollect: begin
                    edmg_q <= edmg_d;
                    pdmg_q <= pdmg_d;
                end
                QDamage: begin
                    edmg_q <= '0;
                    pdmg_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.moveSCEN       = (state_q == QMove);
    assign bus.damageSCEN     = (state_q == QDamage);
    assign bus.busy           = (state_q != QIdle);
    assign bus.enemyFront     = efront_q;
    assign bus.playerFront    = pfront_q;
    assign bus.enemyDamageIn  = edmg_q;
    assign bus.playerDamageIn = pdmg_q;
    assign bus.baseHit        = basehit_q;
    assign bus.overrun        = overrun_q;
`ifdef BATTLE_TICK_CNT_EN
    assign bus.tickCount      = tick_cnt_q;
`endif
endmodule

// File: tb/tb_battlefront_ctrl.sv
// Self-checking bench for battlefront_ctrl (NUM_SLOTS=4, default build).
module tb_battlefront_ctrl;
    localparam int N = 4;

    logic clk, reset;
    int checks, errors;

    battlefront_ctrl_if #(.NUM_SLOTS(N)) bus ();

    battlefront_ctrl #(.NUM_SLOTS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] ePos[N], pPos[N];
    logic [1:0] eTy[N], pTy[N];
    logic [7:0] eDm[N], pDm[N];

    // expected results
    int         ef, pf, efi, pfi;
    logic [31:0] exp_ed, exp_pd;
    bit         bh_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.enemyPos[9*i +: 9]   = ePos[i];
            bus.enemyType[2*i +: 2]  = eTy[i];
            bus.enemyDmg[8*i +: 8]   = eDm[i];
            bus.playerPos[9*i +: 9]  = pPos[i];
            bus.playerType[2*i +: 2] = pTy[i];
            bus.playerDmg[8*i +: 8]  = pDm[i];
        end
    endtask

    // Reference: front = extreme position among alive units, claimed by the
    // lowest slot holding it; sums saturate at 255.
    task automatic model();
        int es, ps;
        ef = 0; pf = 319; efi = -1; pfi = -1; es = 0; ps = 0;
        for (int i = 0; i < N; i++) begin
            if (eTy[i] != 0) begin
                es += eDm[i];
                if (int'(ePos[i]) > ef) ef = ePos[i];
            end
            if (pTy[i] != 0) begin
                ps += pDm[i];
                if (int'(pPos[i]) < pf) pf = pPos[i];
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (eTy[i] != 0 && int'(ePos[i]) == ef) efi = i;
            if (pTy[i] != 0 && int'(pPos[i]) == pf) pfi = i;
        end
        if (es > 255) es = 255;
        if (ps > 255) ps = 255;
        exp_ed = '0;
        exp_pd = '0;
        if (efi >= 0) exp_ed[8*efi +: 8] = ps[7:0];
        if (pfi >= 0) exp_pd[8*pfi +: 8] = es[7:0];
        if (ef >= 300) bh_m = 1'b1;
    endtask

    // One full tick: pulse gameClk, watch strobe timing and the damage cycle
    task automatic run_tick(input string tag);
        int mv_k, dm_k, mv_n, dm_n;
        logic [31:0] ed, pd;
        logic [8:0]  efo, pfo;
        logic        bsy;
        apply();
        model();
        mv_k = -1; dm_k = -1; mv_n = 0; dm_n = 0;
        ed = '0; pd = '0; efo = '0; pfo = '0; bsy = 1'b0;
        bus.gameClk = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) bus.gameClk = 1'b0;
            if (bus.moveSCEN) begin mv_k = k; mv_n++; end
            if (bus.damageSCEN) begin
                dm_k = k; dm_n++;
                ed = bus.enemyDamageIn; pd = bus.playerDamageIn;
                efo = bus.enemyFront; pfo = bus.playerFront; bsy = bus.busy;
            end
        end
        chk({tag, ".move_lat"}, mv_k, 64'd5);
        chk({tag, ".dmg_lat"}, dm_k, 64'd7);
        chk({tag, ".strobe_cnt"}, {mv_n[15:0], dm_n[15:0]}, {16'd1, 16'd1});
        chk({tag, ".efront"}, efo, ef);
        chk({tag, ".pfront"}, pfo, pf);
        chk({tag, ".eDmgIn"}, ed, exp_ed);
        chk({tag, ".pDmgIn"}, pd, exp_pd);
        chk({tag, ".busy_dmg"}, bsy, 1'b1);
        chk({tag, ".idle_after"}, {bus.busy, bus.enemyDamageIn, bus.playerDamageIn}, 65'd0);
        chk({tag, ".baseHit"}, bus.baseHit, bh_m);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        bh_m = 1'b0;
    endtask

    task automatic clear_units();
        for (int i = 0; i < N; i++) begin
            ePos[i] = '0; pPos[i] = '0; eTy[i] = '0; pTy[i] = '0; eDm[i] = '0; pDm[i] = '0;
        end
    endtask

    initial begin
        int mv_n, mv_last;
        checks = 0; errors = 0;
        reset = 1'b1;
        bus.gameClk = 1'b0;
        clear_units();
        apply();
        do_reset();

        // reset state
        chk("rst.strobes", {bus.moveSCEN, bus.damageSCEN, bus.busy}, 3'b000);
        chk("rst.fronts", {bus.enemyFront, bus.playerFront}, {9'd0, 9'd319});
        chk("rst.buses", {bus.enemyDamageIn, bus.playerDamageIn}, 64'd0);
        chk("rst.flags", {bus.baseHit, bus.overrun}, 2'b00);

        // no units alive
        run_tick("empty");

        // directed mix with a tie at 40
        clear_units();
        ePos[0] = 9'd10; ePos[1] = 9'd40; ePos[2] = 9'd40; ePos[3] = 9'd0;
        eTy[0] = 2'd1; eTy[1] = 2'd2; eTy[2] = 2'd3; eTy[3] = 2'd0;
        for (int i = 0; i < N; i++) eDm[i] = 8'h10;
        pPos[0] = 9'd200; pPos[1] = 9'd150; pTy[0] = 2'd1; pTy[1] = 2'd2;
        for (int i = 0; i < N; i++) pDm[i] = 8'h20;
        run_tick("mix");
        chk("mix.eslot1", bus.enemyFront, 9'd40);

        // saturation: four players at 0x80
        for (int i = 0; i < N; i++) begin
            pTy[i] = 2'd1; pDm[i] = 8'h80; pPos[i] = 9'(100 + i);
        end
        run_tick("sat");

        // base line crossing, then sticky across a harmless tick
        clear_units();
        ePos[2] = 9'd300; eTy[2] = 2'd1; eDm[2] = 8'h05;
        run_tick("base");
        clear_units();
        run_tick("base_sticky");

        // randomized ticks
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < N; i++) begin
                eTy[i] = 2'($urandom_range(0, 3));
                pTy[i] = 2'($urandom_range(0, 3));
                ePos[i] = (t % 2 == 0) ? 9'($urandom_range(0, 319)) : 9'(50 * $urandom_range(0, 2));
                pPos[i] = (t % 2 == 0) ? 9'($urandom_range(0, 319)) : 9'(50 * $urandom_range(4, 6));
                eDm[i] = 8'($urandom);
                pDm[i] = 8'($urandom_range(0, 90));
            end
            run_tick($sformatf("rnd%0d", t));
        end

        // back-to-back ticks: one pending serviced, the third dropped
        do_reset();
        clear_units();
        apply();
        mv_n = 0; mv_last = -1;
        bus.gameClk = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            bus.gameClk = (k == 2 || k == 4) ? 1'b1 : 1'b0;
            if (bus.moveSCEN) begin mv_n++; mv_last = k; end
        end
        chk("ovr.moves", mv_n, 64'd2);
        chk("ovr.second_move", mv_last, 64'd13);
        chk("ovr.flag", bus.overrun, 1'b1);

        // reset during QCollect aborts to reset values
        do_reset();
        ePos[0] = 9'd120; eTy[0] = 2'd1; eDm[0] = 8'h11;
        pPos[1] = 9'd200; pTy[1] = 2'd1; pDm[1] = 8'h22;
        apply();
        bus.gameClk = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            bus.gameClk = 1'b0;
        end
        chk("abort.pre_front", bus.enemyFront, 9'd120);
        reset = 1'b1;
        step();
        chk("abort.strobes", {bus.moveSCEN, bus.damageSCEN, bus.busy}, 3'b000);
        chk("abort.fronts", {bus.enemyFront, bus.playerFront}, {9'd0, 9'd319});
        chk("abort.buses", {bus.enemyDamageIn, bus.playerDamageIn}, 64'd0);
        reset = 1'b0;
        step();
        chk("abort.stay_idle", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/battlefront_ctrl.md
Name: battlefront_ctrl

Overview:
- Combat arbiter that drives the moveSCEN/damageSCEN/unitFront/damageIn side of every Enemy and Player unit slot.
- On each rising edge of gameClk it runs one fixed sequence:
  - scan all slots to find the enemy and player fronts;
  - strobe movement;
  - collect the units' damageOut values;
  - route summed damage to the opposing frontmost unit.
- Sits in the top level between the unit arrays and the VGA/score logic.

Parameters:
NUM_SLOTS, 4, unit slots per side (enemies and players alike); range 1..8
FIELD_END, 9'd319, rightmost lane position; playerFront value when no player is alive
BASE_LINE, 9'd300, enemyFront at or beyond this raises baseHit

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
gameClk  input  1  slow game clock level, synchronous to clk; only its rising edge is used
enemyPos  input  9*NUM_SLOTS  enemy positions, slot i at [9i+8:9i]
enemyType  input  2*NUM_SLOTS  enemy types; 2'b00 = dead/empty
enemyDmg  input  8*NUM_SLOTS  enemy damageOut values
playerPos  input  9*NUM_SLOTS  player positions
playerType  input  2*NUM_SLOTS  player types; 2'b00 = dead/empty
playerDmg  input  8*NUM_SLOTS  player damageOut values
moveSCEN  output  1  one-cycle move strobe to all units
damageSCEN  output  1  one-cycle damage strobe to all units
enemyFront  output  9  max position of alive enemies; drives player unitFront
playerFront  output  9  min position of alive players; drives enemy unitFront
enemyDamageIn  output  8*NUM_SLOTS  per-enemy damageIn
playerDamageIn  output  8*NUM_SLOTS  per-player damageIn
busy  output  1  high whenever state is not QIdle
baseHit  output  1  sticky; set when published enemyFront >= BASE_LINE
overrun  output  1  sticky; set when a tick is dropped

Behaviour:
Reset (synchronous, active-high):
- state=QIdle; moveSCEN=0, damageSCEN=0.
- enemyFront=0, playerFront=FIELD_END.
- damage buses all 0; baseHit=0, overrun=0, pending=0, gameClk edge register=0.
- Reset asserted mid-sequence aborts immediately to the reset values.

Tick detection:
- tick = gameClk & ~gameClk_q, where gameClk_q is registered every cycle.
- Tick in QIdle: enter QScan next cycle.
- Tick while busy: set pending.
- Tick while busy with pending already set: tick dropped, overrun <= 1.
- On returning to QIdle with pending=1: clear pending, enter QScan on the next cycle.

States:
- QScan:
  - Index i runs 0..NUM_SLOTS-1, one slot per cycle.
  - Running max of alive enemyPos, starting at 0; running min of alive playerPos, starting at FIELD_END.
  - Ties go to the lowest index; winning slot indices are recorded.
  - The running front values are also scratch registers. Published enemyFront/playerFront update only after the last slot, at the transition to QMove.
- QMove: moveSCEN=1 for exactly one cycle.
- QCollect: one cycle; units' damageOut is now valid.
  - eSum = sum of enemyDmg over alive enemies; pSum = sum of playerDmg over alive players.
  - Each sum is computed at 11 bits and saturated to 8'hFF.
- QDamage: damageSCEN=1 for one cycle.
  - enemyDamageIn[frontmost enemy] = pSum; playerDamageIn[frontmost player] = eSum; all other slots 0.
  - If a side has no alive unit, all of that side's damageIn = 0.
  - The same cycle, all damage buses are cleared on the transition to QIdle.
- Latency: tick edge cycle E → moveSCEN at E+NUM_SLOTS+1 → damageSCEN at E+NUM_SLOTS+3.

Other rules:
- baseHit is evaluated on the published enemyFront.
- Unit types/positions changing during QScan are sampled per slot as visited; no retry.

Optional Feature:
BATTLE_TICK_CNT_EN:
- Defined: adds output tickCount (16 bits), reset 0, incremented on each entry to QMove, wraps 16'hFFFF→0.
- Undefined: port and counter absent; all else identical.

Test Plan:
- Reset, then a single tick with no units alive → enemyFront=0, playerFront=319, moveSCEN at E+5 and damageSCEN at E+7 (NUM_SLOTS=4), all damageIn=0.
- Enemies alive at positions 10/40/40/0 (slot 3 dead), players at 200/150 with types ≠0, players dmg 8'h20 each, enemies dmg 8'h10 each → enemyFront=40, front enemy=slot1, enemyDamageIn slot1=8'h40, playerFront=150, playerDamageIn slot1=8'h30.
- Four players each dmg 8'h80 → pSum saturates to 8'hFF on the frontmost enemy.
- Two ticks while busy, then a third → pending serviced once right after QIdle, third dropped, overrun=1.
- Enemy at 300 alive → baseHit=1 after publish, stays 1 until reset.
- Reset during QCollect → next cycle strobes 0, busy=0, fronts 0/319, buses 0.
